uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_FREQ, default 12000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD (integer truncation), DIV >= 2.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..9, payload bits per frame.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 4, power of two >= 2, transmit buffer entries.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 nrst  in  1  reset, asynchronous, active-low.
REQ-009 data_in  in  DATA_BITS  payload word to enqueue.
REQ-010 data_valid  in  1  data_in is offered this cycle.
REQ-011 data_ready  out  1  FIFO can accept a word this cycle.
REQ-012 tx  out  1  serial line, idle high.
REQ-013 busy  out  1  a frame is on the line or the FIFO is non-empty.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
REQ-015 frame_done  out  1  one-cycle pulse on the last clock of each frame's final stop bit.

Function
REQ-016 A word SHALL be written into the FIFO on every rising edge where data_valid && data_ready; data_in is ignored otherwise.
REQ-017 data_ready SHALL equal (fifo_count != FIFO_DEPTH), combinationally from registered state; a pop in the same cycle SHALL NOT raise data_ready.
REQ-018 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-019 FSM states: IDLE, START, DATA, PAR, STOP; encoding in the shared package.
REQ-020 IDLE -> START on the first clock with fifo_count != 0; the head word SHALL be popped into a shift register on that same edge.
REQ-021 Each bit SHALL last exactly DIV clocks, timed by a baud counter of width $clog2(DIV) that resets to 0 on every state entry.
REQ-022 START drives tx=0 for one bit, then -> DATA.
REQ-023 DATA sends DATA_BITS bits LSB first, tracked by a bit counter; after the last bit -> PAR if PARITY != 0, else -> STOP.
REQ-024 PAR drives XOR of the payload for even parity and its inverse for odd parity.
REQ-025 STOP drives tx=1 for STOP_BITS bit periods; on the final clock, frame_done=1.
REQ-026 After STOP, if the FIFO is non-empty, the FSM SHALL go directly to START with a zero-cycle gap; otherwise it SHALL go to IDLE.
REQ-027 tx SHALL be a registered output, glitch-free, and high in IDLE.
REQ-028 Changes to data_in or data_valid mid-frame SHALL NOT affect the frame in flight.

Reset
REQ-029 nrst low SHALL immediately force tx=1, state=IDLE, FIFO empty (fifo_count=0), baud and bit counters to 0, frame_done=0, busy=0; data_ready reads 1 while in reset.
REQ-030 A reset asserted mid-frame SHALL abort the frame, with no partial stop bit; the first frame after release starts from a clean START.

Structure
REQ-031 Package uart_pkg SHALL hold the state typedef, the parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and a DIV-computation function.
REQ-032 The FIFO SHALL be a separate sub-module uart_fifo (parametrised width and depth, count output); the FSM, baud counter and shifter stay in uart_tx_param.

Verification (CLK_FREQ=1000000, BAUD=100000 -> DIV=10)
REQ-033 8N1: push 0x53 -> tx = 0,1,1,0,0,1,0,1,0,1, each for 10 clocks; frame_done pulses at clock 100; busy falls after it.
REQ-034 8E1 and 8O1: push 0x53 (four ones) -> parity bit 0 (even) or 1 (odd); frame length 110 clocks.
REQ-035 7N2: push 0x7F -> start, seven 1s, two stop bits; total 100 clocks; bit 7 of the input is ignored.
REQ-036 Back-to-back with data_valid held high and FIFO_DEPTH=4: data_ready drops once fifo_count=4; successive frames have no idle gap; output bytes appear in push order.
REQ-037 Assert nrst low at clock 35 of a frame -> tx=1 within that cycle; fifo_count=0; after release, a push of 0xA5 yields a correct, complete frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  // Transmit FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // Parity modes
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clocks per bit period (integer truncation)
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; storage is not reset, pointers and count are.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against occupancy and advance pointers/count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign empty_c   = (count_q == '0);

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO front end, baud counter, shifter and framing FSM.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_done
);

  localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned BAUD_W = $clog2(DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;

  logic                   push_c;
  logic                   pop_c;
  logic [DATA_BITS-1:0]   head_c;
  logic                   head_par_c;
  logic                   fifo_full_c;
  logic                   fifo_empty_c;
  logic                   baud_end_c;
  logic [CNT_W-1:0]       cnt_next_c;

  assign data_ready = !fifo_full_c;
  assign push_c     = data_valid && !fifo_full_c;

  // Transmit buffer
  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push_c),
    .wr_data   (data_in),
    .pop       (pop_c),
    .rd_data_c (head_c),
    .count     (fifo_count),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  // Parity bit for the head word, latched alongside the payload on pop
  assign head_par_c = (^head_c) ^ (PARITY == PAR_ODD);
  assign baud_end_c = (baud_q == BAUD_W'(DIV - 1));

  // Next-state, counters, shifter and registered-output precompute
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q + BAUD_W'(1);
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    pop_c        = 1'b0;
    tx_d         = 1'b1;
    frame_done_d = 1'b0;
    busy_d       = 1'b0;
    cnt_next_c   = '0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty_c) begin
          state_d = ST_START;
          pop_c   = 1'b1;
          shreg_d = head_c;
          par_d   = head_par_c;
        end
      end
      ST_START: begin
        if (baud_end_c) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_end_c) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (baud_end_c) begin
          state_d = ST_STOP;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next frame when data is waiting
            if (!fifo_empty_c) begin
              state_d = ST_START;
              pop_c   = 1'b1;
              shreg_d = head_c;
              par_d   = head_par_c;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line level for the state being entered so tx_q stays aligned with state_q
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      ST_PAR:   tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    frame_done_d = (state_d == ST_STOP) && (baud_d == BAUD_W'(DIV - 1)) &&
                   (bit_d == BIT_W'(STOP_BITS - 1));

    cnt_next_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    busy_d     = (state_d != ST_IDLE) || (cnt_next_c != '0);
  end

  // State and output registers; reset parks the line high immediately
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed scoreboard bench for uart_tx_param across 8N1, 8E1, 8O1 and 7N2 builds.
module tb_uart_tx_param;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int DIV  = 10;
  localparam int NDUT = 4;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic            clk = 1'b0;
  logic            nrst;
  logic [7:0]      data_in;
  logic            data_valid;
  logic [NDUT-1:0] rdy_w, tx_w, busy_w, fd_w;
  logic [2:0]      cnt_w [NDUT];

  frame_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .nrst(nrst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
    .fifo_count(cnt_w[0]), .frame_done(fd_w[0]));

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .nrst(nrst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
    .fifo_count(cnt_w[1]), .frame_done(fd_w[1]));

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .nrst(nrst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]),
    .fifo_count(cnt_w[2]), .frame_done(fd_w[2]));

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .nrst(nrst), .data_in(data_in[6:0]), .data_valid(data_valid),
    .data_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]),
    .fifo_count(cnt_w[3]), .frame_done(fd_w[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start bit, LSB-first payload, optional parity, stop bits
  function automatic logic [15:0] model_frame(input logic [7:0] d, input int nb,
                                              input int par, input int stops,
                                              output int len);
    logic [15:0] f;
    logic        p;
    int          k;
    f = '0;
    p = 1'b0;
    k = 1;
    for (int i = 0; i < nb; i++) begin
      f[k] = d[i];
      p    = p ^ d[i];
      k++;
    end
    if (par == 1) begin
      f[k] = ~p;
      k++;
    end else if (par == 2) begin
      f[k] = p;
      k++;
    end
    for (int s = 0; s < stops; s++) begin
      f[k] = 1'b1;
      k++;
    end
    len = k;
    return f;
  endfunction

  task automatic do_reset();
    nrst       = 1'b0;
    data_valid = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle push into an empty FIFO; the expected frame goes to the scoreboard
  task automatic push_word(input logic [7:0] w, input int nb, input int par, input int stops);
    frame_t f;
    int     ln;
    @(negedge clk);
    data_in    = w;
    data_valid = 1'b1;
    f.bits = model_frame(w, nb, par, stops, ln);
    f.len  = ln;
    sb_q.push_back(f);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Wait for a start bit, then sample every clock of every bit period
  task automatic capture(input int sel, input int len, output logic [15:0] bits,
                         output int fd_idx, output int fd_n, output int start_cyc,
                         output bit stable, output bit found);
    int n;
    bits = '0; fd_idx = 0; fd_n = 0; start_cyc = 0; stable = 1'b1; found = 1'b0; n = 0;
    while (tx_w[sel] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx_w[sel] !== 1'b0) return;
    found     = 1'b1;
    start_cyc = cyc;
    for (int b = 0; b < len; b++) begin
      bits[b] = tx_w[sel];
      for (int k = 0; k < DIV; k++) begin
        if (tx_w[sel] !== bits[b]) stable = 1'b0;
        if (fd_w[sel] === 1'b1) begin
          fd_n++;
          fd_idx = cyc - start_cyc + 1;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic check_frame(input string tag, input int sel, output int start_cyc,
                             output logic [15:0] bits);
    frame_t e;
    int     fi, fn;
    bit     st, fnd;
    bits      = '0;
    start_cyc = 0;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    capture(sel, e.len, bits, fi, fn, start_cyc, st, fnd);
    check({tag, "_start_seen"}, 32'(fnd), 32'd1);
    check({tag, "_bits"}, 32'(bits), 32'(e.bits));
    check({tag, "_bit_stable"}, 32'(st), 32'd1);
    check({tag, "_done_clock"}, 32'(fi), 32'(e.len * DIV));
    check({tag, "_done_pulses"}, 32'(fn), 32'd1);
  endtask

  initial begin
    logic [15:0] bits;
    logic [7:0]  b2b [5];
    int          st [5];
    int          s0, i, guard;
    bit          acc;

    b2b = '{8'h53, 8'hA5, 8'h0F, 8'hC3, 8'h81};
    nrst = 1'b0; data_in = 8'h00; data_valid = 1'b0;

    // Reset state, observed while reset is held
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_tx%0d", d),    32'(tx_w[d]),   32'd1);
      check($sformatf("rst_busy%0d", d),  32'(busy_w[d]), 32'd0);
      check($sformatf("rst_ready%0d", d), 32'(rdy_w[d]),  32'd1);
      check($sformatf("rst_count%0d", d), 32'(cnt_w[d]),  32'd0);
      check($sformatf("rst_done%0d", d),  32'(fd_w[d]),   32'd0);
    end
    nrst = 1'b1;
    @(negedge clk);

    // 8N1 with data_in churning mid-frame
    do_reset();
    push_word(8'h53, 8, 0, 1);
    check("8n1_busy_after_push", 32'(busy_w[0]), 32'd1);
    fork
      check_frame("8n1", 0, s0, bits);
      begin
        repeat (80) begin
          @(negedge clk);
          data_in = 8'($urandom);
        end
      end
    join
    check("8n1_line_pattern", 32'(bits), 32'h02A6);
    check("8n1_busy_after_frame", 32'(busy_w[0]), 32'd0);
    check("8n1_idle_tx", 32'(tx_w[0]), 32'd1);

    // 8E1
    do_reset();
    push_word(8'h53, 8, 2, 1);
    check_frame("8e1", 1, s0, bits);
    check("8e1_parity_bit", 32'(bits[9]), 32'd0);

    // 8O1
    do_reset();
    push_word(8'h53, 8, 1, 1);
    check_frame("8o1", 2, s0, bits);
    check("8o1_parity_bit", 32'(bits[9]), 32'd1);

    // 7N2
    do_reset();
    push_word(8'h7F, 7, 0, 2);
    check_frame("7n2", 3, s0, bits);

    // Back-to-back: valid held high until the buffer fills
    do_reset();
    fork
      begin
        i = 0;
        guard = 0;
        data_valid = 1'b1;
        while (i < 5 && guard < 40) begin
          frame_t f;
          int     ln;
          data_in = b2b[i];
          acc = (rdy_w[0] === 1'b1);
          if (acc) begin
            f.bits = model_frame(b2b[i], 8, 0, 1, ln);
            f.len  = ln;
            sb_q.push_back(f);
          end
          @(negedge clk);
          if (acc) i++;
          guard++;
        end
        check("b2b_accepted", 32'(i), 32'd5);
        data_in = 8'hEE;
        for (int h = 0; h < 4; h++) begin
          check("b2b_full_count", 32'(cnt_w[0]), 32'd4);
          check("b2b_full_ready", 32'(rdy_w[0]), 32'd0);
          @(negedge clk);
        end
        data_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 5; f++) check_frame($sformatf("b2b%0d", f), 0, st[f], bits);
      end
    join
    for (int f = 0; f < 4; f++)
      check($sformatf("b2b_gap%0d", f), 32'(st[f+1] - st[f]), 32'(11 * DIV - DIV));
    check("b2b_busy_end", 32'(busy_w[0]), 32'd0);
    check("b2b_count_end", 32'(cnt_w[0]), 32'd0);

    // Reset at clock 35 of a frame with a second word queued
    do_reset();
    push_word(8'h5A, 8, 0, 1);
    @(negedge clk);
    s0 = cyc;
    check("mid_start_low", 32'(tx_w[0]), 32'd0);
    data_in = 8'h11;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    while (cyc - s0 + 1 < 35) @(negedge clk);
    check("mid_pre_tx", 32'(tx_w[0]), 32'd0);
    check("mid_pre_count", 32'(cnt_w[0]), 32'd1);
    nrst = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx_w[0]), 32'd1);
    check("mid_rst_count", 32'(cnt_w[0]), 32'd0);
    check("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    check("mid_rst_ready", 32'(rdy_w[0]), 32'd1);
    check("mid_rst_done", 32'(fd_w[0]), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_quiet_tx", 32'(tx_w[0]), 32'd1);
    check("post_rst_quiet_busy", 32'(busy_w[0]), 32'd0);
    push_word(8'hA5, 8, 0, 1);
    check_frame("post_rst", 0, s0, bits);
    check("post_rst_busy_end", 32'(busy_w[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
